fft_sched: RTL and testbench
============================

# fft_sched

Sequencer for the two-bank in-place radix-2 DIF FFT datapath. It loads N input samples into the two single-port-per-side RAM banks using a conflict-free bank mapping, then issues LOG2N butterfly stages of N/2 butterflies each, and finally unloads two results per cycle. It drives the bank read/write strobes and addresses, both swap selects, and the twiddle index for the multiplier, and it tracks the datapath pipeline latency.

## Interface
- LOG2N, 6: log2 of the FFT size; N = 2^LOG2N.
- PIPE_LAT, 2: cycles from a bank read strobe to the matching write-back (RAM read + butterfly + multiplier).
- AW, LOG2N-1: bank address width (derived; do not override).
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; accepted in IDLE only.
- valid  in  1  qualifies an input sample during LOAD.
- busy  out  1  high in every state except IDLE.
- input_done  out  1  selects butterfly write-back (1) or raw input (0) as the bank write data.
- we_b0, we_b1, re_b0, re_b1  out  1  bank write and read strobes.
- waddr_b0, waddr_b1, raddr_b0, raddr_b1  out  AW  bank addresses.
- swap0_en  out  1  read-side swap: 1 when the upper operand lives in bank1.
- swap1_en  out  1  write-side swap: swap0_en delayed by PIPE_LAT.
- tw_idx  out  LOG2N-1  twiddle index presented with the read strobe.
- stage  out  $clog2(LOG2N)  current stage number.
- out_valid  out  1  unload data is valid on the bank outputs this cycle.
- done  out  1  one-cycle pulse at the end of UNLOAD.

## Operation
- Mapping: the bank of index k is parity(k), the XOR of all k bits. The address of index k is k>>1.
- States: IDLE, LOAD, COMP, GAP, UNLOAD, DONE.
- IDLE → LOAD on start.
- LOAD:
  - Each valid cycle writes sample k (k = 0..N-1) to bank parity(k) at address k>>1. Only that bank's we is asserted.
  - After sample N-1: input_done=1, go to COMP with stage=0.
- COMP, stage s:
  - Position p = LOG2N-1-s.
  - For butterfly j = 0..N/2-1, one per cycle: u = j with a 0 inserted at bit p; l = u | (1<<p).
  - re_b0 = re_b1 = 1. Bank parity(u) reads address u>>1; the other bank reads address l>>1.
  - swap0_en = parity(u). tw_idx = (j mod 2^p) << s.
- Write-back: exactly PIPE_LAT cycles after each read, both we are high with the same addresses, and swap1_en equals the delayed swap0_en.
- GAP:
  - PIPE_LAT cycles with re = 0 while the write-backs drain.
  - Then stage+1 → COMP. After the last stage, go to UNLOAD.
- UNLOAD: m = 0..N/2-1, one per cycle.
  - Read position pair a = 2m, b = 2m+1. The natural-order option changes these positions (see Configuration).
  - Bank parity(a) reads a>>1; the other bank reads b>>1. swap0_en = parity(a). No writes.
- DONE: done=1 for one cycle, input_done=0, then IDLE.
- start while busy is ignored. valid outside LOAD is ignored.

## Timing
- Reset value of every output is 0; state is IDLE.
- Reset mid-operation aborts immediately: all strobes and pending write-backs are dropped.
- LOAD length = N valid cycles; valid gaps stall LOAD.
- COMP and GAP ignore valid; each stage takes N/2 + PIPE_LAT cycles.
- The first read of stage s+1 comes N/2 + PIPE_LAT cycles after the first read of stage s. The total compute time is LOG2N*(N/2+PIPE_LAT) cycles.
- out_valid is the unload re delayed by 1 cycle (RAM read latency).
- done is asserted the cycle after the last out_valid.

## Configuration
- FFT_SCHED_NATURAL_OUT_EN defined: UNLOAD reads positions a = bitrev(2m) and b = bitrev(2m+1), so the bank outputs carry X[2m] and X[2m+1]. This is conflict-free because a and b differ only in the MSB.
- Not defined: positions are 2m and 2m+1, so the output is in bit-reversed order.

## Structure
- Package fft_sched_pkg holds:
  - the state enum;
  - the default LOG2N and PIPE_LAT values;
  - the functions parity(), bitrev() and insert_zero().
- Sub-module fft_wb_delay: a PIPE_LAT-deep shift register carrying {we, waddr_b0, waddr_b1, swap}. It is cleared by nrst.

## Test plan
- Reset: nrst low mid-COMP → all outputs 0 in the same cycle; after release, state is IDLE and busy=0.
- Load with N=64 and random valid gaps:
  - k=5 → we_b0, waddr_b0=2; k=7 → we_b1, waddr_b1=3.
  - input_done rises after the 64th sample.
  - start pulses during LOAD are ignored.
- Stage 0:
  - j=0 → raddr_b0=0, raddr_b1=16, swap0_en=0.
  - j=1 (u=1, l=33) → raddr_b1=0, raddr_b0=16, swap0_en=1.
  - Write-backs to the same addresses 2 cycles later with swap1_en=1.
- Stage spacing: the stage 1 first read is 34 cycles after the stage 0 first read. Stage 1, j=17 → tw_idx=2.
- Unload without the macro:
  - m=0 reads address 0 in both banks, swap0_en=0, out_valid one cycle later.
  - done follows 32 unload cycles after the final GAP.
- Unload with FFT_SCHED_NATURAL_OUT_EN, m=1:
  - positions bitrev(2)=16 and bitrev(3)=48;
  - raddr_b1=8, raddr_b0=24, swap0_en=1.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared state codes, default sizes and index helpers for the two-bank radix-2 DIF FFT sequencer.
package fft_sched_pkg;

   localparam int LOG2N_DEF    = 6;
   localparam int PIPE_LAT_DEF = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD   = 3'd1;
   localparam state_t ST_COMP   = 3'd2;
   localparam state_t ST_GAP    = 3'd3;
   localparam state_t ST_UNLOAD = 3'd4;
   localparam state_t ST_DONE   = 3'd5;

   // Bank selector: XOR of all index bits, so both operands of any butterfly land in different banks.
   function automatic logic parity(input int unsigned k);
      return ^k;
   endfunction

   function automatic int unsigned bitrev(input int unsigned k, input int n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < n; i++) begin
         r = (r << 1) | ((k >> i) & 32'd1);
      end
      return r;
   endfunction

   function automatic int unsigned insert_zero(input int unsigned j, input int p);
      int unsigned lo_mask;
      lo_mask = (32'd1 << p) - 32'd1;
      return ((j & ~lo_mask) << 1) | (j & lo_mask);
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// PIPE_LAT-deep shift register that replays each butterfly read as its write-back.
module fft_wb_delay #(
   parameter int PIPE_LAT = 2,
   parameter int AW       = 5
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          issue,
   input  logic [AW-1:0] issue_addr_b0,
   input  logic [AW-1:0] issue_addr_b1,
   input  logic          issue_swap,
   output logic          wb_we,
   output logic [AW-1:0] wb_addr_b0,
   output logic [AW-1:0] wb_addr_b1,
   output logic          wb_swap
);

   localparam int W = 2 * AW + 2;

   logic [W-1:0] sr [PIPE_LAT];

   // NOTE: this is a pipeline, not a RAM; every slot is reset so an aborted transform cannot leave a write-back in flight.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            sr[i] <= '0;
         end
      end else begin
         sr[0] <= {issue, issue_addr_b0, issue_addr_b1, issue_swap};
         for (int i = 1; i < PIPE_LAT; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign {wb_we, wb_addr_b0, wb_addr_b1, wb_swap} = sr[PIPE_LAT-1];

endmodule

// File: rtl/fft_sched.sv
// Load / compute / unload sequencer for the two-bank in-place radix-2 DIF FFT.
// Define FFT_SCHED_NATURAL_OUT_EN to unload in natural order instead of bit-reversed order.
module fft_sched
   import fft_sched_pkg::*;
#(
   parameter int LOG2N    = LOG2N_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF,
   parameter int AW       = LOG2N - 1
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start,
   input  logic                       valid,
   output logic                       busy,
   output logic                       input_done,
   output logic                       we_b0,
   output logic                       we_b1,
   output logic                       re_b0,
   output logic                       re_b1,
   output logic [AW-1:0]              waddr_b0,
   output logic [AW-1:0]              waddr_b1,
   output logic [AW-1:0]              raddr_b0,
   output logic [AW-1:0]              raddr_b1,
   output logic                       swap0_en,
   output logic                       swap1_en,
   output logic [LOG2N-2:0]           tw_idx,
   output logic [$clog2(LOG2N)-1:0]   stage,
   output logic                       out_valid,
   output logic                       done
);

   localparam int HALF = 1 << (LOG2N - 1);
   localparam int SW   = $clog2(LOG2N);

   typedef logic [AW-1:0]     addr_t;
   typedef logic [LOG2N-2:0]  tw_t;
   typedef logic [LOG2N-1:0]  cnt_t;

   localparam cnt_t           LAST_K     = {LOG2N{1'b1}};
   localparam cnt_t           LAST_J     = LOG2N'(HALF - 1);
   localparam cnt_t           CNT_HALF   = LOG2N'(HALF);
   localparam cnt_t           LAST_GAP   = LOG2N'(PIPE_LAT - 1);
   localparam logic [SW-1:0]  LAST_STAGE = SW'(LOG2N - 1);

   state_t state;
   cnt_t   cnt;
   logic   issue;
   logic   wb_we;
   addr_t  wb_addr_b0;
   addr_t  wb_addr_b1;
   logic   wb_swap;

   int unsigned idx_k, idx_j, idx_s, idx_u, idx_l, idx_m, idx_a, idx_b;
   int          pos_p;
   logic        bank_sel;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         stage      <= '0;
         input_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_LOAD;
                  cnt   <= '0;
                  stage <= '0;
               end
            end
            ST_LOAD: begin
               if (valid) begin
                  if (cnt == LAST_K) begin
                     state      <= ST_COMP;
                     cnt        <= '0;
                     input_done <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_COMP: begin
               if (cnt == LAST_J) begin
                  state <= ST_GAP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == LAST_GAP) begin
                  cnt <= '0;
                  if (stage == LAST_STAGE) begin
                     state <= ST_UNLOAD;
                     stage <= '0;
                  end else begin
                     state <= ST_COMP;
                     stage <= stage + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_UNLOAD: begin
               // One trailing cycle lets the last read's data appear before DONE.
               if (cnt == CNT_HALF) begin
                  state      <= ST_DONE;
                  cnt        <= '0;
                  input_done <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state == ST_UNLOAD) && (cnt != CNT_HALF);
      end
   end

   // NOTE: every output and temporary gets a default first so no branch can infer a latch.
   always_comb begin
      re_b0    = 1'b0;
      re_b1    = 1'b0;
      raddr_b0 = '0;
      raddr_b1 = '0;
      swap0_en = 1'b0;
      tw_idx   = '0;
      issue    = 1'b0;
      we_b0    = wb_we;
      we_b1    = wb_we;
      waddr_b0 = wb_addr_b0;
      waddr_b1 = wb_addr_b1;
      swap1_en = wb_swap;
      idx_k    = 32'(cnt);
      idx_j    = 32'(cnt);
      idx_m    = 32'(cnt);
      idx_s    = 32'(stage);
      pos_p    = LOG2N - 1 - int'(idx_s);
      idx_u    = insert_zero(idx_j, pos_p);
      idx_l    = idx_u | (32'd1 << pos_p);
`ifdef FFT_SCHED_NATURAL_OUT_EN
      idx_a    = bitrev(2 * idx_m, LOG2N);
      idx_b    = bitrev(2 * idx_m + 1, LOG2N);
`else
      idx_a    = 2 * idx_m;
      idx_b    = 2 * idx_m + 1;
`endif
      bank_sel = 1'b0;

      case (state)
         ST_LOAD: begin
            if (valid) begin
               bank_sel = parity(idx_k);
               if (bank_sel) begin
                  we_b1    = 1'b1;
                  waddr_b1 = addr_t'(idx_k >> 1);
               end else begin
                  we_b0    = 1'b1;
                  waddr_b0 = addr_t'(idx_k >> 1);
               end
            end
         end
         ST_COMP: begin
            bank_sel = parity(idx_u);
            re_b0    = 1'b1;
            re_b1    = 1'b1;
            issue    = 1'b1;
            swap0_en = bank_sel;
            tw_idx   = tw_t'((idx_j & ((32'd1 << pos_p) - 32'd1)) << idx_s);
            if (bank_sel) begin
               raddr_b1 = addr_t'(idx_u >> 1);
               raddr_b0 = addr_t'(idx_l >> 1);
            end else begin
               raddr_b0 = addr_t'(idx_u >> 1);
               raddr_b1 = addr_t'(idx_l >> 1);
            end
         end
         ST_UNLOAD: begin
            if (cnt != CNT_HALF) begin
               bank_sel = parity(idx_a);
               re_b0    = 1'b1;
               re_b1    = 1'b1;
               swap0_en = bank_sel;
               if (bank_sel) begin
                  raddr_b1 = addr_t'(idx_a >> 1);
                  raddr_b0 = addr_t'(idx_b >> 1);
               end else begin
                  raddr_b0 = addr_t'(idx_a >> 1);
                  raddr_b1 = addr_t'(idx_b >> 1);
               end
            end
         end
         default: ;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   fft_wb_delay #(
      .PIPE_LAT (PIPE_LAT),
      .AW       (AW)
   ) u_wb_delay (
      .clk           (clk),
      .nrst          (nrst),
      .issue         (issue),
      .issue_addr_b0 (raddr_b0),
      .issue_addr_b1 (raddr_b1),
      .issue_swap    (swap0_en),
      .wb_we         (wb_we),
      .wb_addr_b0    (wb_addr_b0),
      .wb_addr_b1    (wb_addr_b1),
      .wb_swap       (wb_swap)
   );

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: random valid gaps and ignored start/valid pulses, compared
// against a stage/group/span model of the DIF schedule with a write-back queue.
module tb_fft_sched;

   localparam int LOG2N    = 6;
   localparam int N        = 64;
   localparam int HALF     = 32;
   localparam int PIPE_LAT = 2;
   localparam int AW       = 5;

   logic            clk;
   logic            nrst;
   logic            start;
   logic            valid;
   logic            busy;
   logic            input_done;
   logic            we_b0;
   logic            we_b1;
   logic            re_b0;
   logic            re_b1;
   logic [AW-1:0]   waddr_b0;
   logic [AW-1:0]   waddr_b1;
   logic [AW-1:0]   raddr_b0;
   logic [AW-1:0]   raddr_b1;
   logic            swap0_en;
   logic            swap1_en;
   logic [AW-1:0]   tw_idx;
   logic [2:0]      stage;
   logic            out_valid;
   logic            done;

   int total;
   int bad;
   int cyc;

   typedef struct {
      int due;
      int a0;
      int a1;
      int sw;
   } wb_t;

   wb_t wbq[$];

   fft_sched #(
      .LOG2N    (LOG2N),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .valid      (valid),
      .busy       (busy),
      .input_done (input_done),
      .we_b0      (we_b0),
      .we_b1      (we_b1),
      .re_b0      (re_b0),
      .re_b1      (re_b1),
      .waddr_b0   (waddr_b0),
      .waddr_b1   (waddr_b1),
      .raddr_b0   (raddr_b0),
      .raddr_b1   (raddr_b1),
      .swap0_en   (swap0_en),
      .swap1_en   (swap1_en),
      .tw_idx     (tw_idx),
      .stage      (stage),
      .out_valid  (out_valid),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int par(input int v);
      int r;
      r = 0;
      for (int i = 0; i < LOG2N; i++) r = r ^ ((v >> i) & 1);
      return r;
   endfunction

   function automatic int rev6(input int v);
      int r;
      r = 0;
      for (int i = 0; i < LOG2N; i++) if (((v >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_strobes"},
            32'({busy, input_done, we_b0, we_b1, re_b0, re_b1, swap0_en, swap1_en, out_valid, done}), 0);
      check({tag, "_addrs"}, 32'({waddr_b0, waddr_b1, raddr_b0, raddr_b1}), 0);
      check({tag, "_tw_stage"}, 32'({tw_idx, stage}), 0);
   endtask

   // Expects a write-back this cycle if one is due, otherwise no write strobes at all.
   task automatic check_wb();
      if (wbq.size() > 0 && wbq[0].due == cyc) begin
         check("wb_we0", 32'(we_b0), 1);
         check("wb_we1", 32'(we_b1), 1);
         check("wb_addr0", 32'(waddr_b0), 32'(wbq[0].a0));
         check("wb_addr1", 32'(waddr_b1), 32'(wbq[0].a1));
         check("wb_swap1", 32'(swap1_en), 32'(wbq[0].sw));
         void'(wbq.pop_front());
      end else begin
         check("wb_idle", 32'({we_b0, we_b1}), 0);
      end
   endtask

   task automatic load_all(input bit with_gaps);
      int bank;
      int gaps;
      for (int k = 0; k < N; k++) begin
         gaps = with_gaps ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gaps; g++) begin
            step();
            start = 1'($urandom_range(0, 1));
            valid = 1'b0;
            @(negedge clk);
            check("load_gap_we", 32'({we_b0, we_b1}), 0);
            check("load_busy", 32'(busy), 1);
         end
         step();
         start = 1'b0;
         valid = 1'b1;
         @(negedge clk);
         bank = par(k);
         check("load_we0", 32'(we_b0), 32'(bank == 0));
         check("load_we1", 32'(we_b1), 32'(bank == 1));
         check("load_addr", 32'((bank == 1) ? waddr_b1 : waddr_b0), 32'(k >> 1));
         check("load_input_done", 32'(input_done), 0);
      end
   endtask

   task automatic run_transform();
      int span, u, l, sw, a0, a1, a, b;
      step();
      start = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      load_all(1'b1);

      wbq.delete();
      for (int s = 0; s < LOG2N; s++) begin
         span = N >> (s + 1);
         for (int g = 0; g < N / (2 * span); g++) begin
            for (int i = 0; i < span; i++) begin
               step();
               valid = 1'($urandom_range(0, 1));
               start = 1'($urandom_range(0, 1));
               @(negedge clk);
               u  = g * 2 * span + i;
               l  = u + span;
               sw = par(u);
               a0 = (sw == 1) ? (l >> 1) : (u >> 1);
               a1 = (sw == 1) ? (u >> 1) : (l >> 1);
               check("comp_re", 32'({re_b0, re_b1}), 3);
               check("comp_raddr0", 32'(raddr_b0), 32'(a0));
               check("comp_raddr1", 32'(raddr_b1), 32'(a1));
               check("comp_swap0", 32'(swap0_en), 32'(sw));
               check("comp_tw", 32'(tw_idx), 32'(i << s));
               check("comp_stage", 32'(stage), 32'(s));
               check("comp_input_done", 32'(input_done), 1);
               check_wb();
               wbq.push_back('{due: cyc + PIPE_LAT, a0: a0, a1: a1, sw: sw});
            end
         end
         for (int g = 0; g < PIPE_LAT; g++) begin
            step();
            valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("gap_re", 32'({re_b0, re_b1}), 0);
            check("gap_busy", 32'(busy), 1);
            check_wb();
         end
      end

      for (int m = 0; m <= HALF; m++) begin
         step();
         valid = 1'($urandom_range(0, 1));
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("unl_out_valid", 32'(out_valid), 32'(m > 0));
         check("unl_done", 32'(done), 0);
         check_wb();
         if (m < HALF) begin
`ifdef FFT_SCHED_NATURAL_OUT_EN
            a = rev6(2 * m);
            b = rev6(2 * m + 1);
`else
            a = 2 * m;
            b = 2 * m + 1;
`endif
            sw = par(a);
            a0 = (sw == 1) ? (b >> 1) : (a >> 1);
            a1 = (sw == 1) ? (a >> 1) : (b >> 1);
            check("unl_re", 32'({re_b0, re_b1}), 3);
            check("unl_raddr0", 32'(raddr_b0), 32'(a0));
            check("unl_raddr1", 32'(raddr_b1), 32'(a1));
            check("unl_swap0", 32'(swap0_en), 32'(sw));
         end else begin
            check("unl_tail_re", 32'({re_b0, re_b1}), 0);
         end
      end

      step();
      start = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      check("done_pulse", 32'(done), 1);
      check("done_busy", 32'(busy), 1);
      check("done_input_done", 32'(input_done), 0);
      check("done_out_valid", 32'(out_valid), 0);

      step();
      @(negedge clk);
      check("post_done", 32'(done), 0);
      check("post_busy", 32'(busy), 0);
      check("post_wbq_empty", 32'(wbq.size()), 0);
   endtask

   task automatic run_abort();
      step();
      start = 1'b1;
      valid = 1'b0;
      load_all(1'b0);
      for (int i = 0; i < 7; i++) begin
         step();
         valid = 1'b0;
      end
      @(negedge clk);
      check("abort_pre_busy", 32'(busy), 1);
      check("abort_pre_re", 32'({re_b0, re_b1}), 3);
      check("abort_pre_we", 32'({we_b0, we_b1}), 3);
      #2;
      nrst = 1'b0;
      #1;
      check_zero("abort");
      step();
      nrst = 1'b1;
      @(negedge clk);
      check_zero("abort_rel");
      step();
      start = 1'b1;
      @(negedge clk);
      check("restart_idle", 32'(busy), 0);
      step();
      start = 1'b0;
      @(negedge clk);
      check("restart_busy", 32'(busy), 1);
      check("restart_we", 32'({we_b0, we_b1}), 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      nrst  = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      #2;
      nrst = 1'b0;
      #10;
      check_zero("reset");
      step();
      nrst = 1'b1;
      @(negedge clk);
      check_zero("reset_rel");

      run_transform();
      run_abort();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
